fwft_prog_fifo: RTL and testbench

Parametrised first-word-fallthrough FIFO. It is the next generation of the team's small fallthrough FIFO and is used between NetFPGA pipeline stages.
- Head word is presented on dout whenever the FIFO is non-empty; no read latency.
- Adds run-time programmable full/empty thresholds, an occupancy count, a synchronous flush, and sticky overflow/underflow error flags.

---
 rtl/fwft_prog_fifo_if.sv | 31 +++
 rtl/fwft_prog_fifo.sv | 105 ++++++++++
 tb/tb_fwft_prog_fifo.sv | 202 ++++++++++++++++++++
 3 files changed

// File: rtl/fwft_prog_fifo_if.sv
// Handshake/data bundle for fwft_prog_fifo. The master modport is for the producer/consumer side.
// The slave modport is for the FIFO itself.
interface fwft_prog_fifo_if #(
  parameter int unsigned WIDTH          = 72,
  parameter int unsigned MAX_DEPTH_BITS = 3
);
  logic [WIDTH-1:0]        din;
  logic                    wr_en;
  logic                    rd_en;
  logic                    flush;
  logic [MAX_DEPTH_BITS:0] prog_full_thresh;
  logic [MAX_DEPTH_BITS:0] prog_empty_thresh;
  logic [WIDTH-1:0]        dout;
  logic                    full;
  logic                    empty;
  logic                    prog_full;
  logic                    prog_empty;
  logic [MAX_DEPTH_BITS:0] count;
  logic                    overflow;
  logic                    underflow;

  modport master (
    output din, wr_en, rd_en, flush, prog_full_thresh, prog_empty_thresh,
    input  dout, full, empty, prog_full, prog_empty, count, overflow, underflow
  );

  modport slave (
    input  din, wr_en, rd_en, flush, prog_full_thresh, prog_empty_thresh,
    output dout, full, empty, prog_full, prog_empty, count, overflow, underflow
  );
endinterface

// File: rtl/fwft_prog_fifo.sv
// First-word-fallthrough FIFO with programmable thresholds, occupancy count, synchronous flush
// and overflow/underflow flags. Every output is registered.
module fwft_prog_fifo #(
  parameter int unsigned WIDTH          = 72,
  parameter int unsigned MAX_DEPTH_BITS = 3,
  parameter bit          ERR_STICKY     = 1'b1
) (
  input logic            clk,
  input logic            reset,
  fwft_prog_fifo_if.slave bus
);
  localparam int unsigned Depth = 2 ** MAX_DEPTH_BITS;
  localparam int unsigned PW    = MAX_DEPTH_BITS;
  localparam int unsigned CW    = MAX_DEPTH_BITS + 1;
  localparam logic [PW-1:0] PtrOne   = PW'(1);
  localparam logic [CW-1:0] CntOne   = CW'(1);
  localparam logic [CW-1:0] CntZero  = '0;
  localparam logic [CW-1:0] DepthCnt = CW'(Depth);

  logic [WIDTH-1:0] mem [Depth];

  logic [PW-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic [WIDTH-1:0] dout_q, dout_d;
  logic             full_q, empty_q, prog_full_q, prog_empty_q;
  logic             ovf_q, ovf_d, unf_q, unf_d;
  logic             wr_ok, rd_ok, ovf_cond, unf_cond;

  always_comb begin
    wr_ok    = bus.wr_en && (!full_q || bus.rd_en) && !bus.flush;
    rd_ok    = bus.rd_en && !empty_q && !bus.flush;
    ovf_cond = bus.wr_en && full_q && !bus.rd_en && !bus.flush;
    unf_cond = bus.rd_en && empty_q && !bus.flush;

    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    dout_d   = dout_q;

    if (bus.flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (wr_ok) wr_ptr_d = wr_ptr_q + PtrOne;
      if (rd_ok) rd_ptr_d = rd_ptr_q + PtrOne;
      if (wr_ok && !rd_ok) count_d = count_q + CntOne;
      else if (rd_ok && !wr_ok) count_d = count_q - CntOne;
      // Head comes from memory if a successor is stored, else written word bypasses to head.
      if (rd_ok && count_q > CntOne) dout_d = mem[rd_ptr_q + PtrOne];
      else if (wr_ok && (count_q == CntZero || rd_ok)) dout_d = bus.din;
    end

    if (bus.flush) begin
      ovf_d = 1'b0;
      unf_d = 1'b0;
    end else if (ERR_STICKY) begin
      ovf_d = ovf_q | ovf_cond;
      unf_d = unf_q | unf_cond;
    end else begin
      ovf_d = ovf_cond;
      unf_d = unf_cond;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_ok) mem[wr_ptr_q] <= bus.din;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
      dout_q       <= '0;
      full_q       <= 1'b0;
      empty_q      <= 1'b1;
      prog_full_q  <= 1'b0;
      prog_empty_q <= 1'b1;
      ovf_q        <= 1'b0;
      unf_q        <= 1'b0;
    end else begin
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      count_q      <= count_d;
      dout_q       <= dout_d;
      full_q       <= (count_d == DepthCnt);
      empty_q      <= (count_d == CntZero);
      // Thresholds compare against next-state count so flags line up with count.
      prog_full_q  <= (count_d >= bus.prog_full_thresh);
      prog_empty_q <= (count_d <= bus.prog_empty_thresh);
      ovf_q        <= ovf_d;
      unf_q        <= unf_d;
    end
  end

  assign bus.dout       = dout_q;
  assign bus.full       = full_q;
  assign bus.empty      = empty_q;
  assign bus.prog_full  = prog_full_q;
  assign bus.prog_empty = prog_empty_q;
  assign bus.count      = count_q;
  assign bus.overflow   = ovf_q;
  assign bus.underflow  = unf_q;
endmodule

// File: tb/tb_fwft_prog_fifo.sv
// Directed bench for fwft_prog_fifo: one sticky-error and one pulse-error instance share stimulus.
module tb_fwft_prog_fifo;
  logic        clk;
  logic        reset;
  logic [71:0] din;
  logic        wr_en, rd_en, flush;
  logic [3:0]  pf_th, pe_th;
  int          n_total, n_bad;
  logic [71:0] q[$];

  fwft_prog_fifo_if #(.WIDTH(72), .MAX_DEPTH_BITS(3)) bus_s ();
  fwft_prog_fifo_if #(.WIDTH(72), .MAX_DEPTH_BITS(3)) bus_p ();

  assign bus_s.din = din;
  assign bus_s.wr_en = wr_en;
  assign bus_s.rd_en = rd_en;
  assign bus_s.flush = flush;
  assign bus_s.prog_full_thresh = pf_th;
  assign bus_s.prog_empty_thresh = pe_th;
  assign bus_p.din = din;
  assign bus_p.wr_en = wr_en;
  assign bus_p.rd_en = rd_en;
  assign bus_p.flush = flush;
  assign bus_p.prog_full_thresh = pf_th;
  assign bus_p.prog_empty_thresh = pe_th;

  fwft_prog_fifo #(.WIDTH(72), .MAX_DEPTH_BITS(3), .ERR_STICKY(1'b1)) dut_s (
    .clk   (clk),
    .reset (reset),
    .bus   (bus_s)
  );

  fwft_prog_fifo #(.WIDTH(72), .MAX_DEPTH_BITS(3), .ERR_STICKY(1'b0)) dut_p (
    .clk   (clk),
    .reset (reset),
    .bus   (bus_p)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [71:0] got, input logic [71:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    clk = 1'b0; reset = 1'b1; din = '0; wr_en = 1'b0; rd_en = 1'b0; flush = 1'b0;
    pf_th = 4'd7; pe_th = 4'd2;
    n_total = 0; n_bad = 0;

    // Reset state, observed before any clock edge.
    #2;
    chk("rst_count", 72'(bus_s.count), 72'd0);
    chk("rst_dout", bus_s.dout, 72'd0);
    chk("rst_empty", 72'(bus_s.empty), 72'd1);
    chk("rst_full", 72'(bus_s.full), 72'd0);
    chk("rst_pempty", 72'(bus_s.prog_empty), 72'd1);
    chk("rst_pfull", 72'(bus_s.prog_full), 72'd0);
    chk("rst_ovf", 72'(bus_s.overflow), 72'd0);
    chk("rst_unf", 72'(bus_s.underflow), 72'd0);
    tick();
    reset = 1'b0;

    // Fill with A1..A8, no reads.
    for (int i = 0; i < 8; i++) begin
      din = 72'hA1 + 72'(i); wr_en = 1'b1;
      tick();
      chk("t1_count", 72'(bus_s.count), 72'(i + 1));
      chk("t1_dout", bus_s.dout, 72'hA1);
      chk("t1_empty", 72'(bus_s.empty), 72'd0);
      chk("t1_pfull", 72'(bus_s.prog_full), 72'((i + 1) >= 7));
    end
    wr_en = 1'b0;
    chk("t1_full", 72'(bus_s.full), 72'd1);

    // Overflow while full.
    din = 72'hFF; wr_en = 1'b1;
    tick();
    wr_en = 1'b0;
    chk("t2_ovf_s", 72'(bus_s.overflow), 72'd1);
    chk("t2_ovf_p", 72'(bus_p.overflow), 72'd1);
    chk("t2_count", 72'(bus_s.count), 72'd8);
    chk("t2_dout", bus_s.dout, 72'hA1);
    tick();
    chk("t2_ovf_s_hold", 72'(bus_s.overflow), 72'd1);
    chk("t2_ovf_p_drop", 72'(bus_p.overflow), 72'd0);
    for (int k = 0; k < 8; k++) begin
      rd_en = 1'b1;
      tick();
      chk("t2_rd_count", 72'(bus_s.count), 72'(7 - k));
      chk("t2_rd_dout", bus_s.dout, (k < 7) ? 72'hA2 + 72'(k) : 72'hA8);
      chk("t2_rd_empty", 72'(bus_s.empty), 72'(k == 7));
      chk("t2_rd_pempty", 72'(bus_s.prog_empty), 72'((7 - k) <= 2));
    end
    rd_en = 1'b0;

    // Write+read on empty: write wins, read flagged.
    din = 72'h55; wr_en = 1'b1; rd_en = 1'b1;
    tick();
    wr_en = 1'b0; rd_en = 1'b0;
    chk("t3_unf_s", 72'(bus_s.underflow), 72'd1);
    chk("t3_unf_p", 72'(bus_p.underflow), 72'd1);
    chk("t3_count", 72'(bus_s.count), 72'd1);
    chk("t3_dout", bus_s.dout, 72'h55);
    tick();
    chk("t3_unf_p_drop", 72'(bus_p.underflow), 72'd0);
    chk("t3_unf_s_hold", 72'(bus_s.underflow), 72'd1);

    // Streaming at occupancy 1: bypass path.
    for (int i = 0; i < 20; i++) begin
      din = 72'h100 + 72'(i); wr_en = 1'b1; rd_en = 1'b1;
      tick();
      chk("t4a_count", 72'(bus_s.count), 72'd1);
      chk("t4a_dout", bus_s.dout, 72'h100 + 72'(i));
      chk("t4a_errs_p", 72'({bus_p.overflow, bus_p.underflow}), 72'd0);
    end
    wr_en = 1'b0; rd_en = 1'b0;

    // Refill to 8, then stream at full occupancy across pointer wrap.
    q = {};
    q.push_back(72'h113);
    for (int i = 0; i < 7; i++) begin
      din = 72'h200 + 72'(i); wr_en = 1'b1;
      q.push_back(din);
      tick();
    end
    wr_en = 1'b0;
    chk("t4b_fill_count", 72'(bus_s.count), 72'd8);
    for (int i = 0; i < 20; i++) begin
      din = 72'h300 + 72'(i); wr_en = 1'b1; rd_en = 1'b1;
      q.push_back(din);
      void'(q.pop_front());
      tick();
      chk("t4b_dout", bus_s.dout, q[0]);
      chk("t4b_count", 72'(bus_s.count), 72'd8);
      chk("t4b_full", 72'(bus_s.full), 72'd1);
      chk("t4b_errs_p", 72'({bus_p.overflow, bus_p.underflow}), 72'd0);
    end
    wr_en = 1'b0; rd_en = 1'b0;

    // Flush at count 5 with a concurrent write.
    for (int i = 0; i < 3; i++) begin
      rd_en = 1'b1;
      void'(q.pop_front());
      tick();
    end
    rd_en = 1'b0;
    chk("t5_pre_count", 72'(bus_s.count), 72'd5);
    flush = 1'b1; wr_en = 1'b1; din = 72'hEE;
    tick();
    flush = 1'b0; wr_en = 1'b0;
    chk("t5_count", 72'(bus_s.count), 72'd0);
    chk("t5_empty", 72'(bus_s.empty), 72'd1);
    chk("t5_ovf_s", 72'(bus_s.overflow), 72'd0);
    chk("t5_unf_s", 72'(bus_s.underflow), 72'd0);
    chk("t5_dout_hold", bus_s.dout, q[0]);
    chk("t5_pempty", 72'(bus_s.prog_empty), 72'd1);
    pf_th = 4'd0;
    tick();
    chk("t5_pfull_th0", 72'(bus_s.prog_full), 72'd1);
    pf_th = 4'd7; din = 72'h77; wr_en = 1'b1;
    tick();
    wr_en = 1'b0;
    chk("t5_dout_new", bus_s.dout, 72'h77);
    chk("t5_count_new", 72'(bus_s.count), 72'd1);
    chk("t5_pfull_th7", 72'(bus_s.prog_full), 72'd0);

    // Asynchronous reset in the middle of a burst.
    for (int i = 0; i < 3; i++) begin
      din = 72'h400 + 72'(i); wr_en = 1'b1;
      tick();
    end
    din = 72'h4FF;
    #2;
    reset = 1'b1;
    #1;
    chk("t6_count", 72'(bus_s.count), 72'd0);
    chk("t6_empty", 72'(bus_s.empty), 72'd1);
    chk("t6_dout", bus_s.dout, 72'd0);
    chk("t6_pempty", 72'(bus_s.prog_empty), 72'd1);
    tick();
    reset = 1'b0; wr_en = 1'b0;
    chk("t6_count_rel", 72'(bus_s.count), 72'd0);
    din = 72'h99; wr_en = 1'b1;
    tick();
    wr_en = 1'b0;
    chk("t6_first_dout", bus_s.dout, 72'h99);
    chk("t6_first_count", 72'(bus_s.count), 72'd1);
    chk("t6_first_empty", 72'(bus_s.empty), 72'd0);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end
endmodule
